div_seq: RTL and testbench
==========================

# div_seq

Multi-cycle divide sequencer for the execute stage. Accepts a 32-bit signed or unsigned divide request from EX, runs a radix-2 restoring division over 32 iterations, returns a 64-bit {remainder, quotient} result and drives the pipeline stall request while busy. Sits beside the EX ALU. EX holds its operands stable and `start_i` high until `ready_o` is seen; the HI/LO writeback path consumes the result.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  divide request; held high by EX until result taken
- annul_i  in  1  cancel in-flight divide (flush/exception)
- signed_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
- opdata1_i  in  32  dividend; sampled with start_i
- opdata2_i  in  32  divisor; sampled with start_i
- result_o  out  64  {remainder[63:32], quotient[31:0]}; registered
- ready_o  out  1  result valid; registered
- stallreq_o  out  1  pipeline stall request; combinational = start_i & ~ready_o

## Operation
- States: FREE, BYZERO, ON, END. Reset: state FREE, result_o = 0, ready_o = 0, counter = 0.
- FREE: if start_i & ~annul_i, latch operands. Divisor == 0 -> BYZERO; else -> ON with counter = 0. If signed_i, take absolute values of the operands and record both signs. Else stay FREE, outputs 0.
- ON: if annul_i -> FREE; iteration state discarded, ready_o stays 0.
  - Otherwise, while counter < 32, do one restoring step on a 65-bit working register {partial remainder, dividend}: shift left 1; trial-subtract the divisor from the upper 33 bits; if non-negative, keep the difference and set LSB = 1, else LSB = 0; counter++.
  - When counter == 32: apply sign fix-up, load result_o, set ready_o = 1 -> END.
- Sign fix-up (signed only):
  - Quotient is negated (two's complement) if the operand signs differ.
  - Remainder is negated if the dividend was negative.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
- BYZERO: result_o = 0, ready_o = 1 -> END. No exception is raised; the architectural result is 0.
- END: hold result_o and ready_o while start_i is high. When start_i is low: -> FREE, ready_o = 0, result_o = 0.
- annul_i in FREE blocks acceptance. annul_i in BYZERO or END has no effect.
- rst overrides everything in every state.

## Timing
- Call the edge that samples start_i in FREE "E0".
- Normal divide: ready_o rises after edge E0+33, i.e. 34 edges after E0 counting E0. That is 32 iteration edges plus one finish edge. stallreq_o is high from start_i assertion until ready_o rises.
- Divide by zero: ready_o rises after E0+1.
- Result is stable for at least one cycle. It persists until the first edge with start_i low.
- Back-to-back: a new start is accepted only from FREE. The earliest new E0 is one edge after the edge that sampled start_i low in END.
- annul_i sampled high in ON returns to FREE at that edge. ready_o never pulses for the annulled op.

## Test plan
- Unsigned 100 / 7, start held -> ready_o high exactly 34 edges after E0; result_o = 0x00000002_0000000E. Drop start_i -> next edge ready_o = 0, result_o = 0.
- Signed -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divisor 0 (signed_i = 1, dividend 5) -> ready_o after 2 edges; result_o = 0.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
- annul_i pulsed at iteration 10 -> FREE next edge; ready_o never rises. A subsequent 9 / 3 completes with quotient 3, remainder 0, 34 edges after its E0.
- rst asserted mid-divide (iteration 20) -> next edge all outputs 0, state FREE; stallreq_o follows start_i.

Source files
------------

// File: rtl/div_if.sv
// Request/response bundle between the EX stage and the divide sequencer.
// EX drives the request signals; the sequencer returns the result, ready and stall request.
interface div_if;
   logic        start_i;
   logic        annul_i;
   logic        signed_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stallreq_o;

   modport master (
      output start_i, annul_i, signed_i, opdata1_i, opdata2_i,
      input  result_o, ready_o, stallreq_o
   );

   modport slave (
      input  start_i, annul_i, signed_i, opdata1_i, opdata2_i,
      output result_o, ready_o, stallreq_o
   );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for the EX stage (signed and unsigned).
// The result is {remainder, quotient}; the stall request is held while a request is pending.
module div_seq (
   input logic  clk,
   input logic  rst,
   div_if.slave bus
);

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BYZERO = 2'd1,
      ON     = 2'd2,
      END    = 2'd3
   } state_t;

   state_t      state_r, state_s;
   logic [5:0]  cnt_r, cnt_s;
   logic [64:0] work_r, work_s;
   logic [31:0] dvs_r, dvs_s;
   logic        neg_q_r, neg_q_s;
   logic        neg_rem_r, neg_rem_s;
   logic [63:0] result_r, result_s;
   logic        ready_r, ready_s;
   logic [33:0] diff_s;

   function automatic logic [31:0] abs32(input logic [31:0] v);
      abs32 = v[31] ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic en);
      cond_neg32 = en ? (~v + 32'd1) : v;
   endfunction

   // Trial subtract of the divisor from the partial remainder as it will look after the shift.
   assign diff_s = work_r[64:31] - {2'b00, dvs_r};

   // Next-state and datapath update for the sequencer FSM.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      work_s    = work_r;
      dvs_s     = dvs_r;
      neg_q_s   = neg_q_r;
      neg_rem_s = neg_rem_r;
      result_s  = result_r;
      ready_s   = ready_r;
      case (state_r)
         FREE: begin
            result_s = 64'd0;
            ready_s  = 1'b0;
            if (bus.start_i && !bus.annul_i) begin
               neg_q_s   = bus.signed_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
               neg_rem_s = bus.signed_i & bus.opdata1_i[31];
               work_s    = {33'd0, bus.signed_i ? abs32(bus.opdata1_i) : bus.opdata1_i};
               dvs_s     = bus.signed_i ? abs32(bus.opdata2_i) : bus.opdata2_i;
               cnt_s     = 6'd0;
               if (bus.opdata2_i == 32'd0) begin
                  state_s = BYZERO;
               end else begin
                  state_s = ON;
               end
            end else begin
               state_s = FREE;
            end
         end
         BYZERO: begin
            result_s = 64'd0;
            ready_s  = 1'b1;
            state_s  = END;
         end
         ON: begin
            if (bus.annul_i) begin
               state_s  = FREE;
               cnt_s    = 6'd0;
               result_s = 64'd0;
               ready_s  = 1'b0;
            end else if (cnt_r != 6'd32) begin
               // A non-negative difference means the divisor fits: keep it, quotient bit = 1.
               if (!diff_s[33]) begin
                  work_s = {diff_s[32:0], work_r[30:0], 1'b1};
               end else begin
                  work_s = {work_r[63:0], 1'b0};
               end
               cnt_s = cnt_r + 6'd1;
            end else begin
               result_s = {cond_neg32(work_r[63:32], neg_rem_r),
                           cond_neg32(work_r[31:0], neg_q_r)};
               ready_s  = 1'b1;
               state_s  = END;
            end
         end
         END: begin
            if (bus.start_i) begin
               state_s = END;
            end else begin
               state_s  = FREE;
               result_s = 64'd0;
               ready_s  = 1'b0;
            end
         end
         default: begin
            state_s  = FREE;
            cnt_s    = 6'd0;
            result_s = 64'd0;
            ready_s  = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= FREE;
         cnt_r     <= 6'd0;
         work_r    <= 65'd0;
         dvs_r     <= 32'd0;
         neg_q_r   <= 1'b0;
         neg_rem_r <= 1'b0;
         result_r  <= 64'd0;
         ready_r   <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         work_r    <= work_s;
         dvs_r     <= dvs_s;
         neg_q_r   <= neg_q_s;
         neg_rem_r <= neg_rem_s;
         result_r  <= result_s;
         ready_r   <= ready_s;
      end
   end

   assign bus.result_o   = result_r;
   assign bus.ready_o    = ready_r;
   assign bus.stallreq_o = bus.start_i & ~ready_r;

endmodule

// File: tb/tb_div_seq.sv
// Directed, table-driven bench for div_seq: latency, results, handshake release,
// plus hand-written annul and mid-divide reset sequences.
module tb_div_seq;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   div_if bus ();

   div_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        sg;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic run_div(input string nm, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat);
      int edges;
      bit seen;
      @(negedge clk);
      bus.start_i   = 1'b1;
      bus.signed_i  = sg;
      bus.opdata1_i = a;
      bus.opdata2_i = b;
      edges = 0;
      seen  = 1'b0;
      while (!seen && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
         if (edges == 1) chk({nm, "_stall_busy"}, {63'd0, bus.stallreq_o}, 64'd1);
         if (bus.ready_o) seen = 1'b1;
      end
      chk({nm, "_latency"}, 64'(edges), 64'(lat));
      chk({nm, "_result"}, bus.result_o, exp);
      chk({nm, "_stall_done"}, {63'd0, bus.stallreq_o}, 64'd0);
      @(posedge clk);
      #1;
      chk({nm, "_hold"}, {bus.result_o[62:0], bus.ready_o}, {exp[62:0], 1'b1});
      @(negedge clk);
      bus.start_i = 1'b0;
      @(posedge clk);
      #1;
      chk({nm, "_release"}, {bus.result_o[62:0], bus.ready_o}, 64'd0);
   endtask

   initial begin
      n_pass        = 0;
      n_total       = 0;
      rst           = 1'b1;
      bus.start_i   = 1'b0;
      bus.annul_i   = 1'b0;
      bus.signed_i  = 1'b0;
      bus.opdata1_i = 32'd0;
      bus.opdata2_i = 32'd0;

      vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 34};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 34};
      vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 34};
      vecs[3]  = '{1'b1, 32'd5,          32'd0,          64'h00000000_00000000, 2};
      vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 34};
      vecs[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 34};
      vecs[6]  = '{1'b0, 32'd9,          32'd3,          64'h00000000_00000003, 34};
      vecs[7]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          64'hFFFFFFFE_FFFFFFF2, 34};
      vecs[8]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 34};
      vecs[9]  = '{1'b0, 32'd5,          32'd0,          64'h00000000_00000000, 2};
      vecs[10] = '{1'b0, 32'd3,          32'd10,         64'h00000003_00000000, 34};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {bus.result_o[62:0], bus.ready_o}, 64'd0);
      chk("reset_stall", {63'd0, bus.stallreq_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         run_div($sformatf("v%0d", i), vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      end

      // Annul at iteration 10, then confirm the divider is idle and usable again.
      begin
         int ready_hits;
         ready_hits = 0;
         @(negedge clk);
         bus.start_i   = 1'b1;
         bus.signed_i  = 1'b0;
         bus.opdata1_i = 32'd1000;
         bus.opdata2_i = 32'd7;
         repeat (11) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) ready_hits++;
         end
         @(negedge clk);
         bus.annul_i = 1'b1;
         @(negedge clk);
         bus.annul_i = 1'b0;
         bus.start_i = 1'b0;
         repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.ready_o) ready_hits++;
         end
         chk("annul_no_ready", 64'(ready_hits), 64'd0);
         run_div("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34);
      end

      // Reset at iteration 20 with start still asserted.
      @(negedge clk);
      bus.start_i   = 1'b1;
      bus.signed_i  = 1'b1;
      bus.opdata1_i = 32'hFFFFFF9C;
      bus.opdata2_i = 32'd7;
      repeat (21) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_outputs", {bus.result_o[62:0], bus.ready_o}, 64'd0);
      chk("midrst_stall_hi", {63'd0, bus.stallreq_o}, 64'd1);
      @(negedge clk);
      bus.start_i = 1'b0;
      #1;
      chk("midrst_stall_lo", {63'd0, bus.stallreq_o}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_div("after_rst", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
